cpu_trace_buffer: RTL and testbench
===================================

Name: cpu_trace_buffer

Overview:
- Debug trace stage directly downstream of the multicycle CPU top. Consumes its pc_out and ALU_OUT outputs.
- On every PC update, captures a {pc, alu, timestamp} record into an internal FIFO. Capture can be gated by an arm/trigger state machine.
- Records drain through a first-word-fall-through valid/ready read port to a host or debug UART.

Parameters:
DEPTH, 16, number of FIFO entries (power of two)
ADDR_W, 4, log2(DEPTH)
STOP_ON_FULL, 1, 1: go to DONE when FIFO fills; 0: keep running and drop records while full

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-low reset
pc_in  input  32  CPU pc_out
alu_in  input  32  CPU ALU_OUT
arm  input  1  one-cycle pulse; starts a capture session from IDLE
clear  input  1  one-cycle pulse; flush FIFO and return to IDLE
trig_en  input  1  1: wait for trig_pc before capturing; 0: capture immediately on arm
trig_pc  input  32  trigger PC value
rd_ready  input  1  consumer accepts head record
rd_valid  output  1  head record valid (FIFO non-empty)
rd_pc  output  32  head record PC
rd_alu  output  32  head record ALU value
rd_stamp  output  16  head record cycle timestamp
count  output  ADDR_W+1  current FIFO occupancy
overflow_cnt  output  8  dropped-record count, saturating
state  output  2  FSM state: 0 IDLE, 1 ARMED, 2 CAPTURE, 3 DONE

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE; count=0; rd/wr pointers=0; overflow_cnt=0; stamp counter=0; pc_q=0.
  - rd_valid=0; rd_pc, rd_alu and rd_stamp read 0.
- Timestamp and events:
  - stamp: free-running 16-bit cycle counter; wraps 0xFFFF->0x0000.
  - pc_q: registers pc_in every cycle.
  - event = (pc_in != pc_q), combinational. The first event after reset occurs only if pc_in != 0.
  - An event record is {pc_in, alu_in, stamp}, sampled at the edge ending the event cycle. rd_valid rises the following cycle (1-cycle write latency).
- FSM:
  - IDLE: no capture. arm -> CAPTURE if trig_en=0, else -> ARMED.
  - ARMED: an event with pc_in==trig_pc -> CAPTURE, and that triggering event is written. Non-matching events are ignored.
  - CAPTURE: every event is a write request.
    - STOP_ON_FULL=1: when a write brings count to DEPTH, -> DONE on the same edge.
    - STOP_ON_FULL=0: remain in CAPTURE. A write request while full with no simultaneous pop is dropped and overflow_cnt increments, saturating at 255.
  - DONE: no capture; the FIFO still drains.
  - arm in any state other than IDLE is ignored.
- Priority and interactions:
  - clear has highest priority after reset, in any state. On clear: pointers=0, count=0, overflow_cnt=0, state=IDLE. A simultaneous arm, event or pop is discarded.
- Read port:
  - rd_valid = (count != 0). rd_pc, rd_alu and rd_stamp come combinationally from the head entry.
  - A pop occurs on rd_valid && rd_ready at the edge.
  - The read port is usable in every state.
- Simultaneous push and pop:
  - count is unchanged.
  - When full, a simultaneous pop frees the slot and the write is accepted: no overflow, no DONE transition.
  - When empty, a push with rd_ready=1 does not pop; rd_valid is 0 in that cycle.
- Pointers: wrap modulo DEPTH. count ranges 0..DEPTH.

Decomposition:
- Shared package (cpu_debug_pkg):
  - FSM state encodings (TRC_IDLE=0, TRC_ARMED=1, TRC_CAPTURE=2, TRC_DONE=3).
  - Record width constant, 80 bits.
  - Timestamp width, 16.
- One sub-module, trace_fifo:
  - Synchronous-write, asynchronous-read FWFT FIFO (DEPTH x 80).
  - Provides push, pop, full, empty and count.
  - FSM, event detection, stamp counter and overflow counting stay in the top.

Test Plan:
1. Reset: assert rst=0 mid-capture with count=5 -> count=0, state=0, rd_valid=0 immediately, without waiting for a clock edge.
2. Untriggered capture: trig_en=0, arm; pc_in steps 0->1->2->3 with alu_in=0x10,0x20,0x30 -> three records (1,0x10),(2,0x20),(3,0x30), stamps increasing by the step spacing.
3. Trigger: trig_en=1, trig_pc=0x8, arm; pc_in=4,5,8,9 -> state ARMED until pc 8. Records are only pc 8 and 9.
4. Full, STOP_ON_FULL=1: 16 events with rd_ready=0 -> count=16, state=DONE, 17th event not stored, overflow_cnt=0. Then drain 16 pops in original order.
5. Overflow, STOP_ON_FULL=0: 20 events with rd_ready=0 -> count=16, overflow_cnt=4. A further event with a simultaneous pop is accepted: count stays 16, overflow_cnt stays 4.
6. clear with a coincident arm and event while in DONE with count=9 -> state=IDLE, count=0, overflow_cnt=0, and no capture on that cycle.

Source files
------------

// File: rtl/cpu_debug_pkg.sv
// Shared definitions for the CPU debug trace path: capture FSM encoding and
// the trace record layout.
package cpu_debug_pkg;

    localparam int unsigned STAMP_W = 16;
    localparam int unsigned REC_W   = 80;

    typedef enum logic [1:0] {
        TRC_IDLE    = 2'd0,
        TRC_ARMED   = 2'd1,
        TRC_CAPTURE = 2'd2,
        TRC_DONE    = 2'd3
    } trc_state_e;

    typedef struct packed {
        logic [31:0]        pc;
        logic [31:0]        alu;
        logic [STAMP_W-1:0] stamp;
    } trc_rec_t;

endpackage

// File: rtl/trace_fifo.sv
// First-word-fall-through FIFO for trace records: synchronous write,
// combinational read of the head entry.
module trace_fifo
    import cpu_debug_pkg::*;
#(
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned ADDR_W = 4
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              clear_i,
    input  logic              push_i,
    input  logic              pop_i,
    input  logic [REC_W-1:0]  wdata_i,
    output logic [REC_W-1:0]  rdata_o,
    output logic              full_o,
    output logic              empty_o,
    output logic [ADDR_W:0]   count_o
);

    logic [REC_W-1:0]  mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic              do_push, do_pop;

    assign full_o  = (count_q == (ADDR_W+1)'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign rdata_o = mem[rd_ptr_q];

    // A pop on a full FIFO frees the slot the simultaneous push lands in.
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (clear_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) begin
                wr_ptr_d = wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            if (do_push && !do_pop) begin
                count_d = count_q + 1'b1;
            end else if (do_pop && !do_push) begin
                count_d = count_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push && !clear_i) begin
            mem[wr_ptr_q] <= wdata_i;
        end
    end

endmodule

// File: rtl/cpu_trace_buffer.sv
// CPU trace capture stage: records {pc, alu, stamp} on every PC change,
// gated by an arm/trigger FSM, and drains through a valid/ready port.
module cpu_trace_buffer
    import cpu_debug_pkg::*;
#(
    parameter int unsigned DEPTH        = 16,
    parameter int unsigned ADDR_W       = 4,
    parameter bit          STOP_ON_FULL = 1'b1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [31:0]        pc_in,
    input  logic [31:0]        alu_in,
    input  logic               arm,
    input  logic               clear,
    input  logic               trig_en,
    input  logic [31:0]        trig_pc,
    input  logic               rd_ready,
    output logic               rd_valid,
    output logic [31:0]        rd_pc,
    output logic [31:0]        rd_alu,
    output logic [STAMP_W-1:0] rd_stamp,
    output logic [ADDR_W:0]    count,
    output logic [7:0]         overflow_cnt,
    output logic [1:0]         state
);

    trc_state_e         state_q, state_d;
    logic [31:0]        pc_q;
    logic [STAMP_W-1:0] stamp_q;
    logic [7:0]         ovf_q, ovf_d;

    logic     evt, wr_req, pop, push, drop, fifo_full, fifo_empty;
    trc_rec_t wr_rec, rd_rec;

    assign evt    = (pc_in != pc_q);
    assign wr_rec = '{pc: pc_in, alu: alu_in, stamp: stamp_q};
    assign pop    = rd_valid && rd_ready && !clear;
    assign push   = wr_req && !clear;
    assign drop   = push && fifo_full && !pop;

    always_comb begin
        state_d = state_q;
        wr_req  = 1'b0;
        unique case (state_q)
            TRC_IDLE: begin
                if (arm) begin
                    state_d = trig_en ? TRC_ARMED : TRC_CAPTURE;
                end
            end
            TRC_ARMED: begin
                if (evt && (pc_in == trig_pc)) begin
                    wr_req  = 1'b1;
                    state_d = TRC_CAPTURE;
                end
            end
            TRC_CAPTURE: begin
                wr_req = evt;
            end
            default: ;
        endcase
        // Stop only on the write that takes occupancy to DEPTH.
        if (STOP_ON_FULL && wr_req && !pop && (count == (ADDR_W+1)'(DEPTH - 1))) begin
            state_d = TRC_DONE;
        end
        if (clear) begin
            state_d = TRC_IDLE;
        end
    end

    always_comb begin
        ovf_d = ovf_q;
        if (clear) begin
            ovf_d = '0;
        end else if (drop && (ovf_q != 8'hFF)) begin
            ovf_d = ovf_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= TRC_IDLE;
            pc_q    <= '0;
            stamp_q <= '0;
            ovf_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_in;
            stamp_q <= stamp_q + 1'b1;
            ovf_q   <= ovf_d;
        end
    end

    trace_fifo #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_fifo (
        .clk_i   (clk),
        .rst_ni  (rst),
        .clear_i (clear),
        .push_i  (push),
        .pop_i   (pop),
        .wdata_i (wr_rec),
        .rdata_o (rd_rec),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (count)
    );

    // Head fields are forced to zero when empty so reset reads back zeros.
    assign rd_valid     = !fifo_empty;
    assign rd_pc        = rd_valid ? rd_rec.pc    : '0;
    assign rd_alu       = rd_valid ? rd_rec.alu   : '0;
    assign rd_stamp     = rd_valid ? rd_rec.stamp : '0;
    assign overflow_cnt = ovf_q;
    assign state        = state_q;

endmodule

// File: tb/tb_cpu_trace_buffer.sv
// Bench for cpu_trace_buffer: one instance per STOP_ON_FULL setting, shared
// stimulus, checked against a queue-based model and directed tables.
module tb_cpu_trace_buffer;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pc_in, alu_in, trig_pc;
    logic        arm, clear, trig_en, rd_ready;

    logic        rd_valid_w [2];
    logic [31:0] rd_pc_w    [2];
    logic [31:0] rd_alu_w   [2];
    logic [15:0] rd_stamp_w [2];
    logic [4:0]  count_w    [2];
    logic [7:0]  ovf_w      [2];
    logic [1:0]  state_w    [2];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    cpu_trace_buffer #(.DEPTH(16), .ADDR_W(4), .STOP_ON_FULL(1'b0)) dut0 (
        .clk(clk), .rst(rst), .pc_in(pc_in), .alu_in(alu_in), .arm(arm), .clear(clear),
        .trig_en(trig_en), .trig_pc(trig_pc), .rd_ready(rd_ready),
        .rd_valid(rd_valid_w[0]), .rd_pc(rd_pc_w[0]), .rd_alu(rd_alu_w[0]),
        .rd_stamp(rd_stamp_w[0]), .count(count_w[0]), .overflow_cnt(ovf_w[0]),
        .state(state_w[0])
    );

    cpu_trace_buffer #(.DEPTH(16), .ADDR_W(4), .STOP_ON_FULL(1'b1)) dut1 (
        .clk(clk), .rst(rst), .pc_in(pc_in), .alu_in(alu_in), .arm(arm), .clear(clear),
        .trig_en(trig_en), .trig_pc(trig_pc), .rd_ready(rd_ready),
        .rd_valid(rd_valid_w[1]), .rd_pc(rd_pc_w[1]), .rd_alu(rd_alu_w[1]),
        .rd_stamp(rd_stamp_w[1]), .count(count_w[1]), .overflow_cnt(ovf_w[1]),
        .state(state_w[1])
    );

    // Reference model: index 0 keeps running when full, index 1 stops.
    logic [79:0] mq   [2][$];
    logic [1:0]  ms   [2];
    logic [7:0]  movf [2];
    logic [15:0] mst  [2];
    logic [31:0] mpcq [2];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int m = 0; m < 2; m++) begin
            mq[m].delete();
            ms[m]   = 2'd0;
            movf[m] = 8'd0;
            mst[m]  = 16'd0;
            mpcq[m] = 32'd0;
        end
    endtask

    task automatic model_update(input int m);
        logic       evt, pop, wr;
        logic [1:0] ns;
        int         sz;
        sz  = mq[m].size();
        evt = (pc_in != mpcq[m]);
        pop = (sz != 0) && rd_ready;
        if (clear) begin
            mq[m].delete();
            movf[m] = 8'd0;
            ms[m]   = 2'd0;
        end else begin
            wr = 1'b0;
            ns = ms[m];
            case (ms[m])
                2'd0: if (arm) ns = trig_en ? 2'd1 : 2'd2;
                2'd1: if (evt && pc_in == trig_pc) begin wr = 1'b1; ns = 2'd2; end
                2'd2: wr = evt;
                default: ;
            endcase
            if (pop) void'(mq[m].pop_front());
            if (wr) begin
                if (sz == 16 && !pop) begin
                    if (movf[m] != 8'd255) movf[m] = movf[m] + 8'd1;
                end else begin
                    mq[m].push_back({pc_in, alu_in, mst[m]});
                    if (m == 1 && !pop && sz == 15) ns = 2'd3;
                end
            end
            ms[m] = ns;
        end
        mst[m]  = mst[m] + 16'd1;
        mpcq[m] = pc_in;
    endtask

    task automatic cmp_all();
        logic [79:0] head;
        for (int m = 0; m < 2; m++) begin
            head = (mq[m].size() != 0) ? mq[m][0] : 80'd0;
            chk($sformatf("valid%0d", m), 32'(rd_valid_w[m]), 32'(mq[m].size() != 0));
            chk($sformatf("pc%0d", m),    rd_pc_w[m],         head[79:48]);
            chk($sformatf("alu%0d", m),   rd_alu_w[m],        head[47:16]);
            chk($sformatf("stamp%0d", m), 32'(rd_stamp_w[m]), 32'(head[15:0]));
            chk($sformatf("count%0d", m), 32'(count_w[m]),    32'(mq[m].size()));
            chk($sformatf("ovf%0d", m),   32'(ovf_w[m]),      32'(movf[m]));
            chk($sformatf("state%0d", m), 32'(state_w[m]),    32'(ms[m]));
        end
    endtask

    task automatic step();
        model_update(0);
        model_update(1);
        @(posedge clk);
        #1;
        cmp_all();
    endtask

    typedef struct {
        logic        clr;
        logic        arm;
        logic        ten;
        logic [31:0] pc;
        logic [31:0] alu;
        logic        rdy;
        logic [1:0]  est;
        logic [4:0]  ecnt;
        logic [31:0] epc;
        logic [31:0] ealu;
    } vec_t;

    vec_t tbl [18];

    initial begin
        // Untriggered capture, drain, then triggered capture on pc 8.
        tbl[0]  = '{1'b0, 1'b1, 1'b0, 32'd0, 32'h00, 1'b0, 2'd2, 5'd0, 32'd0, 32'h00};
        tbl[1]  = '{1'b0, 1'b0, 1'b0, 32'd1, 32'h10, 1'b0, 2'd2, 5'd1, 32'd1, 32'h10};
        tbl[2]  = '{1'b0, 1'b0, 1'b0, 32'd1, 32'h10, 1'b0, 2'd2, 5'd1, 32'd1, 32'h10};
        tbl[3]  = '{1'b0, 1'b0, 1'b0, 32'd2, 32'h20, 1'b0, 2'd2, 5'd2, 32'd1, 32'h10};
        tbl[4]  = '{1'b0, 1'b0, 1'b0, 32'd2, 32'h20, 1'b0, 2'd2, 5'd2, 32'd1, 32'h10};
        tbl[5]  = '{1'b0, 1'b0, 1'b0, 32'd3, 32'h30, 1'b0, 2'd2, 5'd3, 32'd1, 32'h10};
        tbl[6]  = '{1'b0, 1'b0, 1'b0, 32'd3, 32'h30, 1'b1, 2'd2, 5'd2, 32'd2, 32'h20};
        tbl[7]  = '{1'b0, 1'b0, 1'b0, 32'd3, 32'h30, 1'b1, 2'd2, 5'd1, 32'd3, 32'h30};
        tbl[8]  = '{1'b0, 1'b0, 1'b0, 32'd3, 32'h30, 1'b1, 2'd2, 5'd0, 32'd0, 32'h00};
        tbl[9]  = '{1'b1, 1'b0, 1'b0, 32'd3, 32'h30, 1'b0, 2'd0, 5'd0, 32'd0, 32'h00};
        tbl[10] = '{1'b0, 1'b1, 1'b1, 32'd3, 32'h30, 1'b0, 2'd1, 5'd0, 32'd0, 32'h00};
        tbl[11] = '{1'b0, 1'b0, 1'b1, 32'd4, 32'h40, 1'b0, 2'd1, 5'd0, 32'd0, 32'h00};
        tbl[12] = '{1'b0, 1'b0, 1'b1, 32'd5, 32'h50, 1'b0, 2'd1, 5'd0, 32'd0, 32'h00};
        tbl[13] = '{1'b0, 1'b0, 1'b1, 32'd8, 32'h80, 1'b0, 2'd2, 5'd1, 32'd8, 32'h80};
        tbl[14] = '{1'b0, 1'b0, 1'b1, 32'd9, 32'h90, 1'b0, 2'd2, 5'd2, 32'd8, 32'h80};
        tbl[15] = '{1'b0, 1'b0, 1'b1, 32'd9, 32'h90, 1'b1, 2'd2, 5'd1, 32'd9, 32'h90};
        tbl[16] = '{1'b0, 1'b0, 1'b1, 32'd9, 32'h90, 1'b1, 2'd2, 5'd0, 32'd0, 32'h00};
        tbl[17] = '{1'b1, 1'b0, 1'b0, 32'd9, 32'h90, 1'b0, 2'd0, 5'd0, 32'd0, 32'h00};

        rst = 1'b0;
        pc_in = '0; alu_in = '0; trig_pc = 32'd8;
        arm = 1'b0; clear = 1'b0; trig_en = 1'b0; rd_ready = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_count", 32'(count_w[1]), 32'd0);
        chk("rst_valid", 32'(rd_valid_w[1]), 32'd0);
        chk("rst_pc", rd_pc_w[1], 32'd0);
        @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < 18; i++) begin
            clear = tbl[i].clr; arm = tbl[i].arm; trig_en = tbl[i].ten;
            pc_in = tbl[i].pc;  alu_in = tbl[i].alu; rd_ready = tbl[i].rdy;
            step();
            chk($sformatf("tbl%0d_state", i), 32'(state_w[1]), 32'(tbl[i].est));
            chk($sformatf("tbl%0d_count", i), 32'(count_w[1]), 32'(tbl[i].ecnt));
            chk($sformatf("tbl%0d_pc", i), rd_pc_w[1], tbl[i].epc);
            chk($sformatf("tbl%0d_alu", i), rd_alu_w[1], tbl[i].ealu);
            chk($sformatf("tbl%0d_state0", i), 32'(state_w[0]), 32'(tbl[i].est));
        end
        clear = 1'b0; trig_en = 1'b0; rd_ready = 1'b0;

        // Fill: stop instance reaches DONE, running instance drops four.
        arm = 1'b1;
        step();
        arm = 1'b0;
        for (int i = 0; i < 20; i++) begin
            pc_in = 32'h100 + 32'(i); alu_in = 32'(i);
            step();
            if (i == 15) begin
                chk("full16_count1", 32'(count_w[1]), 32'd16);
                chk("full16_state1", 32'(state_w[1]), 32'd3);
                chk("full16_state0", 32'(state_w[0]), 32'd2);
            end
        end
        chk("full_count1", 32'(count_w[1]), 32'd16);
        chk("full_ovf1", 32'(ovf_w[1]), 32'd0);
        chk("full_count0", 32'(count_w[0]), 32'd16);
        chk("full_ovf0", 32'(ovf_w[0]), 32'd4);
        chk("full_head1", rd_pc_w[1], 32'h100);
        pc_in = 32'h200; rd_ready = 1'b1;
        step();
        chk("pushpop_count0", 32'(count_w[0]), 32'd16);
        chk("pushpop_ovf0", 32'(ovf_w[0]), 32'd4);
        chk("pushpop_state0", 32'(state_w[0]), 32'd2);
        chk("done_pop_count1", 32'(count_w[1]), 32'd15);
        for (int k = 0; k < 15; k++) begin
            chk($sformatf("drain%0d_pc", k), rd_pc_w[1], 32'h101 + 32'(k));
            step();
        end
        chk("drained_valid1", 32'(rd_valid_w[1]), 32'd0);
        rd_ready = 1'b0;

        // clear with coincident arm and event while DONE with 9 entries.
        clear = 1'b1; step(); clear = 1'b0;
        arm = 1'b1; step(); arm = 1'b0;
        for (int i = 0; i < 16; i++) begin
            pc_in = 32'h300 + 32'(i); step();
        end
        rd_ready = 1'b1;
        repeat (7) step();
        rd_ready = 1'b0;
        chk("pre_clr_count1", 32'(count_w[1]), 32'd9);
        chk("pre_clr_state1", 32'(state_w[1]), 32'd3);
        clear = 1'b1; arm = 1'b1; pc_in = 32'h400; rd_ready = 1'b1;
        step();
        chk("clr_state1", 32'(state_w[1]), 32'd0);
        chk("clr_count1", 32'(count_w[1]), 32'd0);
        chk("clr_ovf0", 32'(ovf_w[0]), 32'd0);
        clear = 1'b0; arm = 1'b0; rd_ready = 1'b0;
        step();
        chk("post_clr_state1", 32'(state_w[1]), 32'd0);
        chk("post_clr_count1", 32'(count_w[1]), 32'd0);

        // Asynchronous reset with five entries buffered.
        arm = 1'b1; step(); arm = 1'b0;
        for (int i = 0; i < 5; i++) begin
            pc_in = 32'h500 + 32'(i); step();
        end
        chk("prerst_count1", 32'(count_w[1]), 32'd5);
        #2 rst = 1'b0;
        #1;
        chk("arst_count1", 32'(count_w[1]), 32'd0);
        chk("arst_state1", 32'(state_w[1]), 32'd0);
        chk("arst_valid1", 32'(rd_valid_w[1]), 32'd0);
        chk("arst_count0", 32'(count_w[0]), 32'd0);
        model_reset();
        #1 rst = 1'b1;

        for (int n = 0; n < 1500; n++) begin
            clear    = ($urandom_range(0, 39) == 0);
            arm      = ($urandom_range(0, 5) == 0);
            trig_en  = 1'($urandom_range(0, 1));
            trig_pc  = 32'($urandom_range(0, 7));
            if ($urandom_range(0, 1) == 0) pc_in = 32'($urandom_range(0, 7));
            alu_in   = $urandom;
            rd_ready = ($urandom_range(0, 3) == 0);
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
